// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that turns ram_dual into a valid/ready stream buffer with a one-entry output register.
// Define RAM_FIFO_ERR_EN to add sticky o_overflow / o_underflow error flags.
module ram_fifo_ctrl #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 32,
    parameter int ADDRESS  = 5,
    parameter int AF_LEVEL = 28,
    parameter int AE_LEVEL = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push_valid,
    output logic               o_push_ready,
    input  logic [WIDTH-1:0]   i_push_data,
    output logic               o_pop_valid,
    input  logic               i_pop_ready,
    output logic [WIDTH-1:0]   o_pop_data,
    output logic               o_ram_cs,
    output logic               o_ram_valid,
    output logic               o_ram_wr_en,
    output logic [ADDRESS-1:0] o_ram_wr_addr,
    output logic [WIDTH-1:0]   o_ram_wr_data,
    output logic               o_ram_rd_en,
    output logic [ADDRESS-1:0] o_ram_rd_addr,
    input  logic [WIDTH-1:0]   i_ram_rd_data,
    input  logic               i_ram_ready,
    output logic [ADDRESS:0]   o_count,
    output logic               o_full,
    output logic               o_empty,
    output logic               o_almost_full,
`ifdef RAM_FIFO_ERR_EN
    output logic               o_overflow,
    output logic               o_underflow,
`endif
    output logic               o_almost_empty
);

    localparam logic [ADDRESS:0] FULL_CNT = DEPTH[ADDRESS:0];
    localparam logic [ADDRESS:0] AF_CNT   = AF_LEVEL[ADDRESS:0];
    localparam logic [ADDRESS:0] AE_CNT   = AE_LEVEL[ADDRESS:0];

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FETCH,
        S_VALID
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [ADDRESS-1:0]   wr_ptr;
    logic [ADDRESS-1:0]   rd_ptr;
    logic [ADDRESS:0]     ram_cnt;
    logic [ADDRESS:0]     count;
    logic [WIDTH-1:0]     pop_data_q;
    logic                 rd_en;
    logic                 push_fire;
    logic                 pop_fire;

    assign o_full         = (count == FULL_CNT);
    assign o_empty        = (count == '0);
    assign o_almost_full  = (count >= AF_CNT);
    assign o_almost_empty = (count <= AE_CNT);
    assign o_count        = count;

    assign o_push_ready = !o_full && i_ram_ready;
    assign push_fire    = i_push_valid && o_push_ready;
    assign o_pop_valid  = (state == S_VALID);
    assign pop_fire     = o_pop_valid && i_pop_ready;
    assign o_pop_data   = pop_data_q;

    assign o_ram_wr_en   = push_fire;
    assign o_ram_valid   = push_fire;
    assign o_ram_wr_addr = wr_ptr;
    assign o_ram_wr_data = i_push_data;
    assign o_ram_rd_en   = rd_en;
    assign o_ram_rd_addr = rd_ptr;
    assign o_ram_cs      = push_fire || rd_en;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= S_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // ram_cnt is registered, so a read only ever targets an entry written at an earlier edge.
    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        case (state)
            S_EMPTY: begin
                if (ram_cnt != '0) begin
                    rd_en      = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                next_state = S_VALID;
            end
            S_VALID: begin
                if (i_pop_ready) begin
                    if (ram_cnt != '0) begin
                        rd_en      = 1'b1;
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_EMPTY;
                    end
                end
            end
            default: begin
                next_state = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_cnt    <= '0;
            count      <= '0;
            pop_data_q <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_fire, rd_en})
                2'b10:   ram_cnt <= ram_cnt + 1'b1;
                2'b01:   ram_cnt <= ram_cnt - 1'b1;
                default: ram_cnt <= ram_cnt;
            endcase
            case ({push_fire, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (state == S_FETCH) begin
                pop_data_q <= i_ram_rd_data;
            end
        end
    end

`ifdef RAM_FIFO_ERR_EN
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_push_valid && o_full) begin
                o_overflow <= 1'b1;
            end
            if (i_pop_ready && !o_pop_valid && o_empty) begin
                o_underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural ram_dual model behind it.
module tb_ram_fifo_ctrl;

    localparam int WIDTH   = 16;
    localparam int DEPTH   = 32;
    localparam int ADDRESS = 5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               push_valid;
    logic               push_ready;
    logic [WIDTH-1:0]   push_data;
    logic               pop_valid;
    logic               pop_ready;
    logic [WIDTH-1:0]   pop_data;
    logic               ram_cs;
    logic               ram_valid;
    logic               ram_wr_en;
    logic [ADDRESS-1:0] ram_wr_addr;
    logic [WIDTH-1:0]   ram_wr_data;
    logic               ram_rd_en;
    logic [ADDRESS-1:0] ram_rd_addr;
    logic [WIDTH-1:0]   ram_rd_data;
    logic               ram_ready;
    logic [ADDRESS:0]   count;
    logic               full;
    logic               empty;
    logic               almost_full;
    logic               almost_empty;
`ifdef RAM_FIFO_ERR_EN
    logic               overflow;
    logic               underflow;
`endif

    logic [WIDTH-1:0]   mem [DEPTH];

    int vec_count  = 0;
    int miss_count = 0;

    typedef struct {
        logic        pv;
        logic [15:0] pd;
        logic        pr;
        logic        e_valid;
        logic [15:0] e_data;
        logic [5:0]  e_count;
        logic        e_empty;
    } vec_t;

    vec_t tbl [15];

    always #5 clk = ~clk;

    ram_fifo_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDRESS(ADDRESS), .AF_LEVEL(28), .AE_LEVEL(4)
    ) dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .i_push_valid(push_valid),
        .o_push_ready(push_ready),
        .i_push_data(push_data),
        .o_pop_valid(pop_valid),
        .i_pop_ready(pop_ready),
        .o_pop_data(pop_data),
        .o_ram_cs(ram_cs),
        .o_ram_valid(ram_valid),
        .o_ram_wr_en(ram_wr_en),
        .o_ram_wr_addr(ram_wr_addr),
        .o_ram_wr_data(ram_wr_data),
        .o_ram_rd_en(ram_rd_en),
        .o_ram_rd_addr(ram_rd_addr),
        .i_ram_rd_data(ram_rd_data),
        .i_ram_ready(ram_ready),
        .o_count(count),
        .o_full(full),
        .o_empty(empty),
        .o_almost_full(almost_full),
`ifdef RAM_FIFO_ERR_EN
        .o_overflow(overflow),
        .o_underflow(underflow),
`endif
        .o_almost_empty(almost_empty)
    );

    // ram_dual model: registered read data one cycle after rd_en
    always @(posedge clk) begin
        if (ram_wr_en && ram_cs) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en && ram_cs) ram_rd_data <= mem[ram_rd_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic pv, input logic [15:0] pd, input logic pr);
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        @(posedge clk);
        @(negedge clk);
        push_valid = 1'b0;
        pop_ready  = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        push_data  = '0;
        ram_ready  = 1'b1;
        rst_n      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pushN(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, base + 16'(i), 1'b0);
    endtask

    task automatic popExpect(input string name, input logic [15:0] expected);
        for (int t = 0; t < 10 && !pop_valid; t++) applyStimulus(1'b0, 16'h0, 1'b0);
        checkOutput({name, " valid"}, {31'd0, pop_valid}, 32'd1);
        checkOutput({name, " data"}, {16'd0, pop_data}, {16'd0, expected});
        applyStimulus(1'b0, 16'h0, 1'b1);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 16'h00A0, 1'b1, 1'b0, 16'h0000, 6'd1, 1'b0};
        tbl[1]  = '{1'b1, 16'h00A1, 1'b1, 1'b0, 16'h0000, 6'd2, 1'b0};
        tbl[2]  = '{1'b1, 16'h00A2, 1'b1, 1'b1, 16'h00A0, 6'd3, 1'b0};
        tbl[3]  = '{1'b1, 16'h00A3, 1'b1, 1'b0, 16'h0000, 6'd3, 1'b0};
        tbl[4]  = '{1'b1, 16'h00A4, 1'b1, 1'b1, 16'h00A1, 6'd4, 1'b0};
        tbl[5]  = '{1'b1, 16'h00A5, 1'b1, 1'b0, 16'h0000, 6'd4, 1'b0};
        tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h00A2, 6'd4, 1'b0};
        tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 6'd3, 1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h00A3, 6'd3, 1'b0};
        tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 6'd2, 1'b0};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h00A4, 6'd2, 1'b0};
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 6'd1, 1'b0};
        tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h00A5, 6'd1, 1'b0};
        tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 6'd0, 1'b1};
        tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 6'd0, 1'b1};

        rst_n      = 1'b1;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        push_data  = '0;
        ram_ready  = 1'b1;
        doReset();

        $display("[TB] reset state");
        checkOutput("rst count", {26'd0, count}, 32'd0);
        checkOutput("rst empty", {31'd0, empty}, 32'd1);
        checkOutput("rst almost_empty", {31'd0, almost_empty}, 32'd1);
        checkOutput("rst full", {31'd0, full}, 32'd0);
        checkOutput("rst almost_full", {31'd0, almost_full}, 32'd0);
        checkOutput("rst pop_valid", {31'd0, pop_valid}, 32'd0);
        checkOutput("rst push_ready", {31'd0, push_ready}, 32'd1);

        $display("[TB] in-order stream table");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i].pv, tbl[i].pd, tbl[i].pr);
            checkOutput($sformatf("tbl%0d pop_valid", i), {31'd0, pop_valid}, {31'd0, tbl[i].e_valid});
            checkOutput($sformatf("tbl%0d count", i), {26'd0, count}, {26'd0, tbl[i].e_count});
            checkOutput($sformatf("tbl%0d empty", i), {31'd0, empty}, {31'd0, tbl[i].e_empty});
            if (tbl[i].e_valid)
                checkOutput($sformatf("tbl%0d data", i), {16'd0, pop_data}, {16'd0, tbl[i].e_data});
        end

        $display("[TB] fill, overflow drop, push+pop at full");
        doReset();
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 16'h0100 + 16'(i), 1'b0);
            checkOutput($sformatf("fill%0d count", i), {26'd0, count}, i + 1);
            checkOutput($sformatf("fill%0d almost_full", i), {31'd0, almost_full}, (i + 1 >= 28) ? 32'd1 : 32'd0);
        end
        checkOutput("full flag", {31'd0, full}, 32'd1);
        checkOutput("full push_ready", {31'd0, push_ready}, 32'd0);
        push_valid = 1'b1;
        push_data  = 16'hFFFF;
        #1;
        checkOutput("full no wr_en", {31'd0, ram_wr_en}, 32'd0);
        applyStimulus(1'b1, 16'hFFFF, 1'b0);
        checkOutput("full drop count", {26'd0, count}, 32'd32);
        checkOutput("full head valid", {31'd0, pop_valid}, 32'd1);
        checkOutput("full head data", {16'd0, pop_data}, 32'h0100);
        applyStimulus(1'b1, 16'hEEEE, 1'b1);
        checkOutput("full push+pop count", {26'd0, count}, 32'd31);
        for (int i = 1; i < 32; i++) popExpect($sformatf("drain%0d", i), 16'h0100 + 16'(i));
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0, 1'b0);
        checkOutput("drain empty", {31'd0, empty}, 32'd1);
        checkOutput("drain no extra", {31'd0, pop_valid}, 32'd0);

        $display("[TB] write pointer wrap");
        doReset();
        pushN(32, 16'h0200);
        popExpect("wrap first", 16'h0200);
        push_valid = 1'b1;
        push_data  = 16'h0BEE;
        #1;
        checkOutput("wrap wr_en", {31'd0, ram_wr_en}, 32'd1);
        checkOutput("wrap wr_addr", {27'd0, ram_wr_addr}, 32'd0);
        applyStimulus(1'b1, 16'h0BEE, 1'b0);
        checkOutput("wrap count", {26'd0, count}, 32'd32);
        for (int i = 1; i < 32; i++) popExpect($sformatf("wrap%0d", i), 16'h0200 + 16'(i));
        popExpect("wrap last", 16'h0BEE);

        $display("[TB] latency and hold");
        doReset();
        push_valid = 1'b1;
        push_data  = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        push_valid = 1'b0;
        checkOutput("lat E0 valid", {31'd0, pop_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("lat E1 valid", {31'd0, pop_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("lat E2 valid", {31'd0, pop_valid}, 32'd1);
        checkOutput("lat E2 data", {16'd0, pop_data}, 32'h1234);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 16'h0, 1'b0);
            checkOutput($sformatf("hold%0d valid", i), {31'd0, pop_valid}, 32'd1);
            checkOutput($sformatf("hold%0d data", i), {16'd0, pop_data}, 32'h1234);
        end
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("lat popped empty", {31'd0, empty}, 32'd1);

        $display("[TB] push+pop at count 10");
        doReset();
        pushN(10, 16'h0300);
        checkOutput("c10 count", {26'd0, count}, 32'd10);
        checkOutput("c10 valid", {31'd0, pop_valid}, 32'd1);
        applyStimulus(1'b1, 16'h030A, 1'b1);
        checkOutput("c10 push+pop count", {26'd0, count}, 32'd10);

        $display("[TB] ram not ready");
        doReset();
        ram_ready = 1'b0;
        #1;
        checkOutput("nrdy push_ready", {31'd0, push_ready}, 32'd0);
        applyStimulus(1'b1, 16'h7777, 1'b0);
        checkOutput("nrdy count", {26'd0, count}, 32'd0);
        ram_ready = 1'b1;
        #1;
        checkOutput("rdy push_ready", {31'd0, push_ready}, 32'd1);

        $display("[TB] reset mid-stream");
        doReset();
        pushN(8, 16'h0400);
        push_valid = 1'b1;
        push_data  = 16'h0408;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst empty", {31'd0, empty}, 32'd1);
        checkOutput("midrst pop_valid", {31'd0, pop_valid}, 32'd0);
        checkOutput("midrst count", {26'd0, count}, 32'd0);
        @(negedge clk);
        push_valid = 1'b0;
        rst_n      = 1'b1;
        applyStimulus(1'b1, 16'h5555, 1'b0);
        popExpect("after rst", 16'h5555);

`ifdef RAM_FIFO_ERR_EN
        $display("[TB] error flags");
        doReset();
        checkOutput("ovf reset", {31'd0, overflow}, 32'd0);
        pushN(32, 16'h0600);
        checkOutput("ovf before", {31'd0, overflow}, 32'd0);
        applyStimulus(1'b1, 16'hFFFF, 1'b0);
        checkOutput("ovf set", {31'd0, overflow}, 32'd1);
        applyStimulus(1'b0, 16'h0, 1'b1);
        applyStimulus(1'b0, 16'h0, 1'b0);
        checkOutput("ovf sticky", {31'd0, overflow}, 32'd1);
        doReset();
        checkOutput("ovf cleared", {31'd0, overflow}, 32'd0);
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("udf set", {31'd0, underflow}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
